rf_write_port_ctrl: RTL and testbench
=====================================

// Module: rf_write_port_ctrl
// PURPOSE
//  Single-owner driver of the regfile write port (we3/wa3/wd3); the decode-side read port is the other end.
//  Merges in-order WB-stage writes with out-of-order long-latency (divider) results.
//  Divider results are buffered in a small FIFO; the WB pipe always has priority.
//  pend_mask lets decode stall on RAW hazards against still-queued divider results.
// PARAMETERS
//  DIV_FIFO_DEPTH  2   divider-result buffer entries; power of 2, >=2
//  AW              5   register address width
//  DW              32  data width
// PORTS
//  clk             in   1    clock; all state updates on posedge
//  resetn          in   1    asynchronous reset, active-low
//  pipe_we         in   1    WB-stage write request, no backpressure
//  pipe_wa         in   AW   WB-stage destination register
//  pipe_wd         in   DW   WB-stage write data
//  div_valid       in   1    divider result valid
//  div_wa          in   AW   divider destination register
//  div_wd          in   DW   divider result data
//  div_ready       out  1    buffer can accept; transfer = div_valid & div_ready
//  we3             out  1    regfile write enable, registered
//  wa3             out  AW   regfile write address, registered
//  wd3             out  DW   regfile write data, registered
//  pend_mask       out  2**AW  bit i=1: live queued divider write to reg i
// BEHAVIOUR
//  - Reset (resetn low, async): we3=0, wa3=0, wd3=0, FIFO empty, pend_mask=0, div_ready=0. div_ready goes to 1 on the first posedge after release.
//  - Write selection is evaluated at each posedge. The selected write appears on we3/wa3/wd3 after the edge for exactly 1 cycle.
//  - The regfile commits the write on the following negedge. Latency from input sample to regfile commit is 1/2 cycle after the output edge.
//  - Priority 1: pipe_we=1 -> output {pipe_wa, pipe_wd}.
//  - Priority 2: otherwise, if the FIFO head is live -> pop the head and output it.
//  - Priority 3: otherwise, if the FIFO is empty and a div transfer occurs -> bypass it to the output. It is not enqueued.
//  - Otherwise we3=0. wa3/wd3 hold their previous values.
//  - A div transfer not consumed by the bypass is pushed at the tail. Push and pop in the same cycle are legal.
//  - div_ready = !full, from registered count only. When full, ready stays 0 even if a pop occurs that cycle.
//  - Write-after-write: when pipe_we=1 and pipe_wa matches a live FIFO entry, that entry is marked dead. The pipe write is younger and wins.
//    Dead entries are popped silently in priority-2 slots; we3 stays 0 for them.
//  - Address 0: any write targeting r0 is consumed (popped/accepted) but we3 is forced to 0.
//  - pend_mask is the OR of one-hot(wa) over live FIFO entries. It updates at the same posedge as push/pop/kill. An entry being output this cycle is not pending.
//  - Pointers wrap modulo DIV_FIFO_DEPTH. count is clog2(DEPTH)+1 bits and never exceeds DEPTH.
//  - Reset asserted mid-operation discards all queued results. Upstream must reissue.
// CONFIGURATION
//  RF_WR_STATS_EN defined: adds two output ports, both 32-bit, saturating at 32'hFFFF_FFFF, reset to 0:
//    stall_cnt  out 32  counts cycles with div_valid & !div_ready
//    kill_cnt   out 32  counts FIFO entries killed by WAW
//  RF_WR_STATS_EN undefined: neither port nor the counters exist; all other behaviour is identical.
// TESTING
//  - Reset: hold resetn=0 with random inputs -> we3=0, div_ready=0, pend_mask=0. After release: div_ready=1.
//  - Bypass: FIFO empty, pipe_we=0, div {wa=5, wd=32'h1234} -> next cycle we3=1, wa3=5, wd3=32'h1234; pend_mask stays 0.
//  - Contention: pipe_we=1 for 4 cycles while div pushes r3 then r4.
//    -> div_ready=0 once 2 entries are queued; pend_mask=0x18.
//    -> after pipe_we drops: r3 written, then r4, in order; pend_mask returns to 0.
//  - WAW kill: queue r7=32'hAAAA, then pipe_we to r7=32'hBBBB -> only r7=32'hBBBB written; the next pop slot has we3=0; pend_mask[7] clears.
//  - r0: div wa=0 accepted -> we3 stays 0 and pend_mask[0] never sets.
//  - Async reset with 2 entries queued -> outputs clear immediately without a clock edge; the queued writes never appear.

Source files
------------

// File: rtl/rf_write_port_ctrl.sv
// rf_write_port_ctrl: sole driver of the regfile write port (we3/wa3/wd3).
// Merges in-order WB-stage writes with out-of-order divider results. Divider
// results wait in a small FIFO, and the WB pipe always wins the port.
// pend_mask exposes live queued destinations so decode can stall on RAW.
// Optional build macro: RF_WR_STATS_EN adds saturating stall_cnt / kill_cnt.
module rf_write_port_ctrl #(
    parameter int DIV_FIFO_DEPTH = 2,
    parameter int AW             = 5,
    parameter int DW             = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pipe_we,
    input  logic [AW-1:0]     pipe_wa,
    input  logic [DW-1:0]     pipe_wd,
    input  logic              div_valid,
    input  logic [AW-1:0]     div_wa,
    input  logic [DW-1:0]     div_wd,
    output logic              div_ready,
    output logic              we3,
    output logic [AW-1:0]     wa3,
    output logic [DW-1:0]     wd3,
`ifdef RF_WR_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       kill_cnt,
`endif
    output logic [2**AW-1:0]  pend_mask
);

    localparam int PW = $clog2(DIV_FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DIV_FIFO_DEPTH-1:0][AW-1:0] q_wa;
    logic [DIV_FIFO_DEPTH-1:0][DW-1:0] q_wd;
    logic [DIV_FIFO_DEPTH-1:0]         q_live;   // entry occupied and not killed/r0
    logic [DIV_FIFO_DEPTH-1:0]         kill;
    logic [PW-1:0]                     rd_ptr, wr_ptr;
    logic [CW-1:0]                     count;
    logic                              init_q;   // holds ready low until first edge after reset

    logic          empty, full, xfer, do_pop, bypass, do_push;
    logic          sel_we;
    logic [AW-1:0] sel_wa;
    logic [DW-1:0] sel_wd;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DIV_FIFO_DEPTH));
    assign div_ready = init_q & ~full;
    assign xfer      = div_valid & div_ready;
    // Head is popped in every slot the pipe leaves free, live or dead.
    assign do_pop    = ~pipe_we & ~empty;
    assign bypass    = ~pipe_we & empty & xfer;
    assign do_push   = xfer & ~bypass;

    // WAW: a pipe write supersedes any older queued write to the same register.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DIV_FIFO_DEPTH; i++)
            kill[i] = pipe_we & q_live[i] & (q_wa[i] == pipe_wa);
    end

    // Port arbitration: pipe, then FIFO head, then bypass; r0 never writes.
    always_comb begin
        sel_we = 1'b0;
        sel_wa = pipe_wa;
        sel_wd = pipe_wd;
        if (pipe_we) begin
            sel_we = (pipe_wa != '0);
        end else if (!empty) begin
            sel_we = q_live[rd_ptr];
            sel_wa = q_wa[rd_ptr];
            sel_wd = q_wd[rd_ptr];
        end else if (bypass) begin
            sel_we = (div_wa != '0);
            sel_wa = div_wa;
            sel_wd = div_wd;
        end
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= sel_we;
            if (sel_we) begin
                wa3 <= sel_wa;
                wd3 <= sel_wd;
            end
        end
    end

    // Divider result FIFO: push at tail, pop at head, kill marks entries dead.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_wa   <= '0;
            q_wd   <= '0;
            q_live <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            init_q <= 1'b0;
        end else begin
            init_q <= 1'b1;
            q_live <= q_live & ~kill;
            if (do_pop) begin
                q_live[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                q_wa[wr_ptr]   <= div_wa;
                q_wd[wr_ptr]   <= div_wd;
                q_live[wr_ptr] <= (div_wa != '0);
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Pending destinations: one-hot OR over live entries.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DIV_FIFO_DEPTH; i++)
            if (q_live[i]) pend_mask[q_wa[i]] = 1'b1;
    end

`ifdef RF_WR_STATS_EN
    logic [CW-1:0] kill_n;

    // Number of entries killed this cycle (same register may be queued twice).
    always_comb begin
        kill_n = '0;
        for (int i = 0; i < DIV_FIFO_DEPTH; i++)
            kill_n = kill_n + CW'(kill[i]);
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (div_valid && !div_ready && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (kill_cnt > 32'hFFFF_FFFF - 32'(kill_n))
                kill_cnt <= 32'hFFFF_FFFF;
            else
                kill_cnt <= kill_cnt + 32'(kill_n);
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_port_ctrl.sv
// Self-checking bench for rf_write_port_ctrl: directed vector table, hand
// sequences for reset corners, and random traffic against a queue model.
module tb_rf_write_port_ctrl;

    localparam int DEPTH = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          pipe_we, div_valid;
    logic [AW-1:0] pipe_wa, div_wa;
    logic [DW-1:0] pipe_wd, div_wd;
    logic          div_ready, we3;
    logic [AW-1:0] wa3;
    logic [DW-1:0] wd3;
    logic [31:0]   pend_mask;
`ifdef RF_WR_STATS_EN
    logic [31:0]   stall_cnt, kill_cnt;
`endif

    int nchk  = 0;
    int nfail = 0;
    int stalls = 0;
    int kills  = 0;

    rf_write_port_ctrl #(.DIV_FIFO_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .resetn(resetn),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .div_valid(div_valid), .div_wa(div_wa), .div_wd(div_wd),
        .div_ready(div_ready), .we3(we3), .wa3(wa3), .wd3(wd3),
`ifdef RF_WR_STATS_EN
        .stall_cnt(stall_cnt), .kill_cnt(kill_cnt),
`endif
        .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pwe;
        logic [AW-1:0] pwa;
        logic [DW-1:0] pwd;
        logic          dv;
        logic [AW-1:0] dwa;
        logic [DW-1:0] dwd;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic          e_rdy;
        logic [31:0]   e_pend;
    } row_t;

    typedef struct {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        bit            live;
    } ent_t;

    row_t rows[18];
    ent_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                         input logic dv, input logic [AW-1:0] dwa, input logic [DW-1:0] dwd);
        pipe_we = pwe; pipe_wa = pwa; pipe_wd = pwd;
        div_valid = dv; div_wa = dwa; div_wd = dwd;
    endtask

    task automatic drive_rand();
        drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), $urandom);
    endtask

    // One cycle against the queue model: compute expectation, clock, compare.
    task automatic model_cycle(input string tag);
        bit            rdy, xfer, e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [31:0]   e_pend;
        ent_t          e;
        rdy  = mq.size() < DEPTH;
        xfer = div_valid && rdy;
        if (div_valid && !rdy) stalls++;
        e_we = 0; e_wa = '0; e_wd = '0;
        if (pipe_we) begin
            e_we = (pipe_wa != 0); e_wa = pipe_wa; e_wd = pipe_wd;
            foreach (mq[i])
                if (mq[i].live && mq[i].wa == pipe_wa) begin
                    mq[i].live = 0;
                    kills++;
                end
            if (xfer) mq.push_back('{div_wa, div_wd, div_wa != 0});
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            e_we = e.live; e_wa = e.wa; e_wd = e.wd;
            if (xfer) mq.push_back('{div_wa, div_wd, div_wa != 0});
        end else if (xfer) begin
            e_we = (div_wa != 0); e_wa = div_wa; e_wd = div_wd;
        end
        e_pend = '0;
        foreach (mq[i]) if (mq[i].live) e_pend[mq[i].wa] = 1'b1;
        @(posedge clk); #1;
        chk({tag, " we3"}, 64'(we3), 64'(e_we));
        if (e_we) begin
            chk({tag, " wa3"}, 64'(wa3), 64'(e_wa));
            chk({tag, " wd3"}, 64'(wd3), 64'(e_wd));
        end
        chk({tag, " div_ready"}, 64'(div_ready), 64'(mq.size() < DEPTH));
        chk({tag, " pend_mask"}, 64'(pend_mask), 64'(e_pend));
    endtask

    initial begin
        logic prev_rdy;

        // Directed vectors, applied from an empty FIFO with ready high.
        //            pwe pwa pwd           dv dwa dwd           we wa wd          rdy pend
        rows[0]  = '{0, 0,  0,            1, 5, 32'h1234,     1, 5,  32'h1234, 1, 32'h0};
        rows[1]  = '{0, 0,  0,            0, 0, 0,            0, 0,  0,        1, 32'h0};
        rows[2]  = '{1, 10, 32'hA0,       1, 3, 32'h33,       1, 10, 32'hA0,   1, 32'h08};
        rows[3]  = '{1, 11, 32'hA1,       1, 4, 32'h44,       1, 11, 32'hA1,   0, 32'h18};
        rows[4]  = '{1, 12, 32'hA2,       1, 6, 32'h66,       1, 12, 32'hA2,   0, 32'h18};
        rows[5]  = '{1, 13, 32'hA3,       0, 0, 0,            1, 13, 32'hA3,   0, 32'h18};
        rows[6]  = '{0, 0,  0,            0, 0, 0,            1, 3,  32'h33,   1, 32'h10};
        rows[7]  = '{0, 0,  0,            0, 0, 0,            1, 4,  32'h44,   1, 32'h0};
        rows[8]  = '{1, 9,  32'h99,       1, 7, 32'hAAAA,     1, 9,  32'h99,   1, 32'h80};
        rows[9]  = '{1, 7,  32'hBBBB,     0, 0, 0,            1, 7,  32'hBBBB, 1, 32'h0};
        rows[10] = '{0, 0,  0,            0, 0, 0,            0, 0,  0,        1, 32'h0};
        rows[11] = '{1, 9,  32'h98,       1, 0, 32'h5,        1, 9,  32'h98,   1, 32'h0};
        rows[12] = '{0, 0,  0,            0, 0, 0,            0, 0,  0,        1, 32'h0};
        rows[13] = '{0, 0,  0,            1, 0, 32'h6,        0, 0,  0,        1, 32'h0};
        rows[14] = '{1, 0,  32'h7,        0, 0, 0,            0, 0,  0,        1, 32'h0};
        rows[15] = '{1, 1,  32'h11,       1, 2, 32'h22,       1, 1,  32'h11,   1, 32'h04};
        rows[16] = '{0, 0,  0,            1, 3, 32'h33,       1, 2,  32'h22,   1, 32'h08};
        rows[17] = '{0, 0,  0,            0, 0, 0,            1, 3,  32'h33,   1, 32'h0};

        // Reset held with random inputs: everything stays cleared.
        resetn = 1'b0;
        drive_rand();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst we3", 64'(we3), 0);
            chk("rst div_ready", 64'(div_ready), 0);
            chk("rst pend_mask", 64'(pend_mask), 0);
            drive_rand();
        end
        chk("rst wa3", 64'(wa3), 0);
        chk("rst wd3", 64'(wd3), 0);
        drive(0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        #1;
        chk("release ready low", 64'(div_ready), 0);
        @(posedge clk); #1;
        chk("release ready high", 64'(div_ready), 1);
        chk("release we3", 64'(we3), 0);

        // Table-driven directed sequence.
        prev_rdy = 1'b1;
        for (int r = 0; r < 18; r++) begin
            drive(rows[r].pwe, rows[r].pwa, rows[r].pwd, rows[r].dv, rows[r].dwa, rows[r].dwd);
            if (rows[r].dv && !prev_rdy) stalls++;
            @(posedge clk); #1;
            chk($sformatf("row%0d we3", r), 64'(we3), 64'(rows[r].e_we));
            if (rows[r].e_we) begin
                chk($sformatf("row%0d wa3", r), 64'(wa3), 64'(rows[r].e_wa));
                chk($sformatf("row%0d wd3", r), 64'(wd3), 64'(rows[r].e_wd));
            end
            chk($sformatf("row%0d div_ready", r), 64'(div_ready), 64'(rows[r].e_rdy));
            chk($sformatf("row%0d pend_mask", r), 64'(pend_mask), 64'(rows[r].e_pend));
            prev_rdy = rows[r].e_rdy;
        end
        kills = 1;

        // Random traffic against the queue model (FIFO empty here).
        for (int c = 0; c < 2000; c++) begin
            drive_rand();
            model_cycle($sformatf("rnd%0d", c));
        end
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            model_cycle($sformatf("drain%0d", c));
        end
        chk("drained", 64'(mq.size()), 0);
`ifdef RF_WR_STATS_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(stalls));
        chk("kill_cnt", 64'(kill_cnt), 64'(kills));
`endif

        // Queue two results, then assert reset mid-cycle.
        drive(1, 20, 32'h20, 1, 21, 32'h21);
        @(posedge clk); #1;
        chk("ar q1 wa3", 64'(wa3), 20);
        drive(1, 22, 32'h22, 1, 23, 32'h23);
        @(posedge clk); #1;
        chk("ar q2 we3", 64'(we3), 1);
        chk("ar q2 ready", 64'(div_ready), 0);
        chk("ar q2 pend", 64'(pend_mask), 64'h00A0_0000);
        drive(0, 0, 0, 0, 0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("ar we3", 64'(we3), 0);
        chk("ar ready", 64'(div_ready), 0);
        chk("ar pend", 64'(pend_mask), 0);
        chk("ar wa3", 64'(wa3), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post ar%0d we3", c), 64'(we3), 0);
            chk($sformatf("post ar%0d pend", c), 64'(pend_mask), 0);
        end
`ifdef RF_WR_STATS_EN
        chk("post ar kill_cnt", 64'(kill_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
